// File: rtl/fir_pkg.sv
// Shared widths, types and the saturation helper for the FIR output path.
package fir_pkg;

    localparam int unsigned AUDIO_W   = 16;
    localparam int unsigned ACC_W     = 32;
    localparam int unsigned SAT_CNT_W = 8;

    // Saturation result: audio sample plus a flag set when clipping occurred.
    typedef struct packed {
        logic [AUDIO_W-1:0] sample;
        logic               sat;
    } audio_sat_t;

    localparam logic signed [ACC_W:0] AUDIO_MAX =
        {{(ACC_W - AUDIO_W + 2){1'b0}}, {(AUDIO_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] AUDIO_MIN =
        {{(ACC_W - AUDIO_W + 2){1'b1}}, {(AUDIO_W - 1){1'b0}}};

    function automatic audio_sat_t sat_to_audio(input logic signed [ACC_W:0] value);
        audio_sat_t res;
        res.sample = value[AUDIO_W-1:0];
        res.sat    = 1'b0;
        if (value > AUDIO_MAX) begin
            res.sample = {1'b0, {(AUDIO_W - 1){1'b1}}};
            res.sat    = 1'b1;
        end else if (value < AUDIO_MIN) begin
            res.sample = {1'b1, {(AUDIO_W - 1){1'b0}}};
            res.sat    = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/fir_output_stage_fifo.sv
// Synchronous FIFO with a registered first-word-fall-through head and fill count.
// A push into a full FIFO is accepted when a pop happens on the same edge.
module sync_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   fill
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_next;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] head_d;
    logic             valid_q;
    logic             do_push;
    logic             do_pop;

    // Handshake qualification, occupancy and next head word.
    always_comb begin
        do_pop  = pop && (cnt_q != '0);
        do_push = push && ((cnt_q != CNT_FULL) || do_pop);
        rd_next = rd_ptr_q + PTR_W'(1);

        cnt_d = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - CNT_ONE;
        end

        // Head holds its last value when the FIFO drains.
        head_d = head_q;
        if (do_pop) begin
            if (cnt_q == CNT_ONE) begin
                if (do_push) begin
                    head_d = push_data;
                end
            end else begin
                head_d = mem_q[rd_next];
            end
        end else if (do_push && (cnt_q == '0)) begin
            head_d = push_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
        end else if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_next;
            end
            cnt_q   <= cnt_d;
            head_q  <= head_d;
            valid_q <= (cnt_d != '0);
        end
    end

    // Storage needs no reset: pointers and count define what is live.
    always_ff @(posedge clk_i) begin
        if (do_push && !clr) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head  = head_q;
    assign valid = valid_q;
    assign fill  = cnt_q;

endmodule

// File: rtl/fir_output_stage.sv
// FIR output stage: rounding arithmetic right shift, saturation to audio width,
// and a small FIFO toward the audio transmitter with saturation/drop reporting.
module fir_output_stage
    import fir_pkg::*;
#(
    parameter int unsigned IN_W       = ACC_W,
    parameter int unsigned OUT_W      = AUDIO_W,
    parameter int unsigned SHIFT_W    = 5,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clr_i,
    input  logic [SHIFT_W-1:0]            shift_i,
    input  logic [IN_W-1:0]               in_data_i,
    input  logic                          in_valid_i,
    output logic [OUT_W-1:0]              out_data_o,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   fill_o,
    output logic [SAT_CNT_W-1:0]          sat_cnt_o,
    output logic                          drop_o
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0]     FILL_FULL   = CNT_W'(FIFO_DEPTH);
    localparam logic [SAT_CNT_W-1:0] SAT_CNT_MAX = '1;

    logic signed [IN_W:0] ext;
    logic signed [IN_W:0] rnd;
    logic signed [IN_W:0] s1_d;
    logic signed [IN_W:0] s1_q;
    logic                 s1_valid_q;
    logic [OUT_W-1:0]     s2_data_q;
    logic                 s2_valid_q;
    logic [SAT_CNT_W-1:0] sat_cnt_q;
    logic                 drop_q;
    audio_sat_t           sat_res;
    logic                 fifo_pop;
    logic                 fifo_full;

    // Round half toward +inf, then arithmetic shift; the extra bit absorbs the carry.
    always_comb begin
        ext = {in_data_i[IN_W-1], in_data_i};
        rnd = '0;
        if (shift_i != '0) begin
            rnd = (IN_W + 1)'(1) << (shift_i - SHIFT_W'(1));
        end
        s1_d = (ext + rnd) >>> shift_i;
    end

    assign sat_res   = sat_to_audio(s1_q);
    assign fifo_pop  = out_valid_o && out_ready_i;
    assign fifo_full = (fill_o == FILL_FULL);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q       <= '0;
            s1_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_valid_q <= 1'b0;
            sat_cnt_q  <= '0;
            drop_q     <= 1'b0;
        end else if (clr_i) begin
            s1_q       <= '0;
            s1_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_valid_q <= 1'b0;
            sat_cnt_q  <= '0;
            drop_q     <= 1'b0;
        end else begin
            s1_valid_q <= in_valid_i;
            if (in_valid_i) begin
                s1_q <= s1_d;
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_data_q <= OUT_W'(sat_res.sample);
            end
            if (s1_valid_q && sat_res.sat && (sat_cnt_q != SAT_CNT_MAX)) begin
                sat_cnt_q <= sat_cnt_q + SAT_CNT_W'(1);
            end
            // A push into a full FIFO without a simultaneous pop is lost.
            if (s2_valid_q && fifo_full && !fifo_pop) begin
                drop_q <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr       (clr_i),
        .push      (s2_valid_q),
        .push_data (s2_data_q),
        .pop       (out_ready_i),
        .head      (out_data_o),
        .valid     (out_valid_o),
        .fill      (fill_o)
    );

    assign sat_cnt_o = sat_cnt_q;
    assign drop_o    = drop_q;

endmodule

// File: tb/tb_fir_output_stage.sv
// Bench for fir_output_stage: directed corner cases plus random traffic against
// a sample-level reference model (arithmetic rescale, queue-based output buffer).
module tb_fir_output_stage;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        clr_i;
    logic [4:0]  shift_i;
    logic [31:0] in_data_i;
    logic        in_valid_i;
    logic [15:0] out_data_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [3:0]  fill_o;
    logic [7:0]  sat_cnt_o;
    logic        drop_o;

    always #5 clk_i = ~clk_i;

    fir_output_stage dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clr_i       (clr_i),
        .shift_i     (shift_i),
        .in_data_i   (in_data_i),
        .in_valid_i  (in_valid_i),
        .out_data_o  (out_data_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .fill_o      (fill_o),
        .sat_cnt_o   (sat_cnt_o),
        .drop_o      (drop_o)
    );

    int total = 0;
    int bad   = 0;

    // Reference state: buffered samples, last shown word, two-stage delay line.
    logic [15:0] q[$];
    logic [15:0] last_out;
    logic        p1v, p2v, p1sat;
    logic [15:0] p1d, p2d;
    int          m_sat;
    logic        m_drop;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Value = floor((x + 2^(s-1)) / 2^s), clipped to the 16-bit range.
    function automatic logic [16:0] ref_model(input logic [31:0] d, input logic [4:0] sh);
        longint v;
        v = longint'($signed(d));
        if (sh != 5'd0) v = v + (longint'(1) << (sh - 5'd1));
        v = v >>> sh;
        if (v > 32767)  return {1'b1, 16'h7FFF};
        if (v < -32768) return {1'b1, 16'h8000};
        return {1'b0, 16'(v)};
    endfunction

    task automatic model_reset();
        q.delete();
        last_out = '0;
        p1v = 1'b0; p2v = 1'b0; p1sat = 1'b0;
        p1d = '0;   p2d = '0;
        m_sat = 0;
        m_drop = 1'b0;
    endtask

    task automatic check_all();
        check("valid",   32'(out_valid_o), 32'(q.size() != 0));
        check("fill",    32'(fill_o),      32'(q.size()));
        check("data",    32'(out_data_o),  32'((q.size() != 0) ? q[0] : last_out));
        check("sat_cnt", 32'(sat_cnt_o),   32'(m_sat));
        check("drop",    32'(drop_o),      32'(m_drop));
    endtask

    // One clock: drive inputs, advance the model across the edge, compare.
    task automatic step(input logic v, input logic [31:0] d, input logic [4:0] sh,
                        input logic rdy, input logic clr);
        logic        pop, push;
        logic [16:0] r;
        in_valid_i = v; in_data_i = d; shift_i = sh; out_ready_i = rdy; clr_i = clr;
        @(posedge clk_i);
        if (clr) begin
            model_reset();
        end else begin
            pop  = (q.size() != 0) && rdy;
            push = 1'b0;
            if (p2v) begin
                if ((q.size() < 8) || pop) push = 1'b1;
                else m_drop = 1'b1;
            end
            if (pop) last_out = q.pop_front();
            if (push) q.push_back(p2d);
            if (p1v && p1sat && (m_sat < 255)) m_sat++;
            p2v = p1v; p2d = p1d;
            r = ref_model(d, sh);
            p1v = v; p1d = r[15:0]; p1sat = r[16];
        end
        #1;
        check_all();
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 32'h0, 5'd0, rdy, 1'b0);
    endtask

    task automatic single(input logic [31:0] d, input logic [4:0] sh,
                          input logic [15:0] exp, input string tag);
        step(1'b1, d, sh, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        check(tag, 32'(out_data_o), 32'(exp));
        check({tag, "_valid"}, 32'(out_valid_o), 32'd1);
        idle(1'b1);
    endtask

    task automatic pulse_reset();
        rst_ni = 1'b0;
        #2;
        model_reset();
        check_all();
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic fill_then_flush(input logic use_rst, input string tag);
        step(1'b0, 32'h0, 5'd0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) step(1'b1, 32'h7FFF_FFFF, 5'd0, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 32'h0000_0100, 5'd4, 1'b0, 1'b0);
        if (use_rst) pulse_reset();
        else step(1'b0, 32'h0, 5'd0, 1'b0, 1'b1);
        check({tag, "_valid0"}, 32'(out_valid_o), 32'd0);
        check({tag, "_fill0"},  32'(fill_o),      32'd0);
        check({tag, "_sat0"},   32'(sat_cnt_o),   32'd0);
        check({tag, "_drop0"},  32'(drop_o),      32'd0);
        step(1'b1, 32'h0000_0050, 5'd4, 1'b0, 1'b0);
        check({tag, "_k"}, 32'(out_valid_o), 32'd0);
        idle(1'b0);
        check({tag, "_k1"}, 32'(out_valid_o), 32'd0);
        idle(1'b0);
        check({tag, "_k2_valid"}, 32'(out_valid_o), 32'd1);
        check({tag, "_k2_data"},  32'(out_data_o),  32'h0005);
        idle(1'b1);
    endtask

    initial begin
        logic [31:0] d;
        logic [4:0]  sh;
        rst_ni = 1'b0; clr_i = 1'b0; shift_i = '0; in_data_i = '0;
        in_valid_i = 1'b0; out_ready_i = 1'b0;
        model_reset();
        #12;
        check_all();
        rst_ni = 1'b1;

        // Rounding and saturation corners.
        single(32'h0000_4000, 5'd15, 16'h0001, "half_pos");
        single(32'hFFFF_C000, 5'd15, 16'h0000, "half_neg");
        single(32'h0001_0000, 5'd0,  16'h7FFF, "sat_pos");
        check("sat_cnt1", 32'(sat_cnt_o), 32'd1);
        single(32'hFFFE_0000, 5'd0,  16'h8000, "sat_neg");
        check("sat_cnt2", 32'(sat_cnt_o), 32'd2);
        single(32'h7FFF_FFFF, 5'd4,  16'h7FFF, "no_wrap");
        single(32'h0000_0120, 5'd4,  16'h0012, "shift4");

        // Overflow: nine strobes into an eight-entry buffer with no consumer.
        step(1'b0, 32'h0, 5'd0, 1'b0, 1'b1);
        for (int i = 1; i <= 9; i++) step(1'b1, 32'(i) << 4, 5'd4, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        check("ovf_fill", 32'(fill_o), 32'd8);
        check("ovf_drop", 32'(drop_o), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            check("ovf_order", 32'(out_data_o), 32'(i));
            idle(1'b1);
        end
        check("ovf_empty", 32'(out_valid_o), 32'd0);
        check("ovf_hold",  32'(out_data_o),  32'd8);

        // Full buffer: push and pop on the same edge.
        step(1'b0, 32'h0, 5'd0, 1'b0, 1'b1);
        for (int i = 1; i <= 9; i++) step(1'b1, 32'(i) << 4, 5'd4, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b1);
        check("full_pp_fill", 32'(fill_o),     32'd8);
        check("full_pp_drop", 32'(drop_o),     32'd0);
        check("full_pp_head", 32'(out_data_o), 32'd2);
        for (int i = 2; i <= 9; i++) begin
            check("full_pp_order", 32'(out_data_o), 32'(i));
            idle(1'b1);
        end

        // In-flight samples discarded by a sync clear and by an async reset.
        fill_then_flush(1'b0, "clr");
        fill_then_flush(1'b1, "rst");

        // Saturation counter sticks at its maximum.
        step(1'b0, 32'h0, 5'd0, 1'b1, 1'b1);
        for (int i = 0; i < 260; i++) step(1'b1, 32'h8000_0000, 5'd0, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);
        check("sat_stick", 32'(sat_cnt_o), 32'd255);

        // Random traffic: slow consumer first, then a fast one.
        for (int n = 0; n < 1200; n++) begin
            d  = $urandom;
            sh = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 0) begin
                d  = 32'($signed(d[19:0]));
                sh = 5'($urandom_range(0, 8));
            end
            if (n == 700) pulse_reset();
            step($urandom_range(0, 9) < 6, d, sh,
                 (n < 500) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 9) < 8),
                 $urandom_range(0, 199) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
